// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Round-robin arbiter that shares one downstream channel among four
// packet-based requesters. Ownership is taken in IDLE, held for a whole
// packet (until a transfer with last), then released with one idle bubble.
// An optional beat limit forces a release on long packets.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid[3:0]      per-requester valid
//   in_last[3:0]       per-requester end-of-packet, qualified by valid
//   in_data0..3        per-requester payloads
//   in_ready[3:0]      per-requester ready (only the owner's bit can be set)
//   out_valid/out_data/out_last, out_ready   downstream channel
//   grant[1:0]         current or most recent owner
//   busy               high while a packet is locked
module mux4_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_valid,
  input  logic [3:0]       in_last,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [1:0]       grant,
  output logic             busy
);

  // Wide enough to hold MAX_BEATS; at least one bit when the limit is off.
  localparam int BW = $clog2(MAX_BEATS + 2);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      grant_q, grant_d;
  logic [BW-1:0]   beat_q, beat_d;

  logic [WIDTH-1:0] data_arr [4];
  logic [1:0]       cand [4];
  logic [3:0]       cand_req;
  logic [1:0]       winner;
  logic             any_req;
  logic             xfer;
  logic [BW-1:0]    beat_inc;
  logic             limit_hit;

  assign data_arr[0] = in_data0;
  assign data_arr[1] = in_data1;
  assign data_arr[2] = in_data2;
  assign data_arr[3] = in_data3;

  // Candidate k is the requester k+1 places above the last owner; the
  // 2-bit addition wraps modulo 4, giving the rotating priority order.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_scan
      assign cand[gi]     = ptr_q + 2'(gi + 1);
      assign cand_req[gi] = in_valid[cand[gi]];
    end
  endgenerate

  // Lowest-numbered requesting candidate wins (scan from the top down so
  // the last assignment is the highest-priority one).
  always_comb begin
    winner = cand[0];
    for (int k = 3; k >= 0; k--) begin
      if (cand_req[k]) winner = cand[k];
    end
  end

  assign any_req   = |in_valid;
  assign xfer      = (state_q == LOCKED) && in_valid[grant_q] && out_ready;
  assign beat_inc  = beat_q + BW'(1);
  assign limit_hit = (MAX_BEATS > 0) && (beat_inc == BW'(MAX_BEATS));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      grant_q <= 2'd0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = LOCKED;
          grant_d = winner;
          beat_d  = '0;
        end
      end
      LOCKED: begin
        if (xfer) begin
          beat_d = beat_inc;
          // Release on end of packet, or forcibly once the beat limit is
          // reached; the rest of a cut packet waits for a later grant.
          if (in_last[grant_q] || limit_hit) begin
            state_d = IDLE;
            ptr_d   = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: zero-latency pass-through from the owner while locked.
  always_comb begin
    in_ready  = 4'b0000;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    if (state_q == LOCKED) begin
      out_valid         = in_valid[grant_q];
      out_data          = data_arr[grant_q];
      out_last          = in_last[grant_q];
      in_ready[grant_q] = out_ready;
    end
  end

  assign busy  = (state_q == LOCKED);
  assign grant = grant_q;

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one downstream WIDTH-bit channel among four packet-based requesters. It wraps a 4:1 data select with a valid/ready handshake on every port. The grant is held for a whole packet, delimited by `last`. It sits in front of any single-consumer resource (FIFO, serializer, bus master) that four sources must share.

## Interface
- `WIDTH`, 8, data width of every input and the output channel.
- `MAX_BEATS`, 0, forced-release limit in beats per packet; 0 disables the limit.

- `clk`  input  1  single clock; all logic is rising-edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  4  per-requester valid; bit i belongs to requester i.
- `in_last`  input  4  per-requester end-of-packet flag, qualified by `in_valid`.
- `in_data0`..`in_data3`  input  WIDTH each  requester payloads.
- `in_ready`  output  4  per-requester ready; at most one bit set.
- `out_valid`  output  1  downstream valid.
- `out_data`  output  WIDTH  downstream payload.
- `out_last`  output  1  downstream end-of-packet.
- `out_ready`  input  1  downstream ready.
- `grant`  output  2  index of the current or most recent owner.
- `busy`  output  1  high while a packet is locked (state LOCKED).

## Operation
- A transfer on a port occurs in any cycle where its valid and ready are both 1.
- States:
  - IDLE: no owner. `in_ready`=0, `out_valid`=0, `out_last`=0, `out_data`=0.
  - LOCKED: owner = `grant`.
- IDLE -> LOCKED when any `in_valid` bit is set.
  - The winner is the first set bit scanning upward (mod 4) from `ptr`+1, where `ptr` is the last owner.
  - `grant` <= winner; beat counter <= 0.
- In LOCKED, the datapath is combinational pass-through from requester `grant`:
  - `out_valid` = `in_valid[grant]`, `out_data` = `in_data{grant}`, `out_last` = `in_last[grant]`.
  - `in_ready[grant]` = `out_ready`; the other three `in_ready` bits are 0.
- LOCKED -> IDLE on a transfer with `out_last`=1; `ptr` <= `grant`.
- Beat counter (log2 width sufficient for MAX_BEATS):
  - Increments on each LOCKED transfer.
  - If MAX_BEATS>0 and a transfer makes the count reach MAX_BEATS without `last`, take a forced release: LOCKED -> IDLE and `ptr` <= `grant`.
  - After a forced release, the requester's remaining beats continue in a later grant. Packet integrity is the requester's concern.
- If the owner drops `in_valid` mid-packet, the lock is kept: `out_valid`=0 and no timeout applies (MAX_BEATS counts beats, not cycles).
- `out_ready`=0 stalls: the state is held and `in_ready[grant]`=0.
- `grant` holds its value in IDLE, so it always shows the last owner.
- Requests that arrive while LOCKED are ignored until the return to IDLE. No request is lost, because requesters hold valid until ready.

## Timing
- Reset values:
  - state IDLE, `ptr`=3 (requester 0 has first priority), `grant`=0, beat counter 0.
  - `busy`=0, `in_ready`=4'b0000, `out_valid`=0, `out_last`=0, `out_data`=0.
- Arbitration latency: a request seen in IDLE at cycle N gives `busy`=1 and a valid grant at N+1. The first transfer is possible at N+1.
- Turnaround: after the `last` transfer at cycle M, the block is IDLE at M+1 and the next owner is LOCKED at M+2. There is exactly one bubble per packet.
- Data path latency in LOCKED: 0 cycles, since valid, data, last and ready are combinational.
- `rst` asserted mid-packet: at the next edge, all reset values are restored. The interrupted packet is abandoned and no output beat is generated in the reset cycle's successor.
- Simultaneous requests on all four inputs with `ptr`=3: grant order is 0, 1, 2, 3, 0, ...

## Test plan
- **Reset priority:** after reset, raise `in_valid`=4'b1111, all single-beat packets (`last`=1), `out_ready`=1 → `grant` sequence 0, 1, 2, 3, 0 with one IDLE cycle between beats; `out_data` matches each input.
- **Packet lock:** requester 2 sends a 3-beat packet (0xA1, 0xA2, 0xA3 with `last` on beat 3) while requester 0 is valid → `out_data` = A1, A2, A3 contiguous; requester 0 is granted only after A3 plus one idle cycle; `in_ready[0]`=0 throughout.
- **Backpressure and gap:** hold `out_ready`=0 for 3 cycles mid-packet, then drop the owner's `in_valid` for 2 cycles → no transfer occurs, `busy` stays 1, `grant` is unchanged, and beats resume in order with no duplication.
- **Forced release:** MAX_BEATS=4, requester 1 streams 6 beats with no `last` while requester 3 is waiting → after 4 beats the block goes IDLE; the next grant is 3, then 1 resumes with beats 5–6.
- **Single requester:** only requester 3 is active with repeated 1-beat packets → it is re-granted every 2 cycles; `ptr` wraparound from 3 to 0 and the scan back to 3 are exercised.
- **Reset mid-packet:** assert `rst` during beat 2 of a 4-beat packet from requester 1 → the next cycle shows `busy`=0, `grant`=0, `in_ready`=0; with all requesting afterward, requester 0 wins first.
